// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared pipeline constants, ALU op encodings and control bundle
package riscv_pipe_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic alu_src;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
        logic branch;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detector.sv
// load_use_detector: flags an ID instruction that reads the destination of a load sitting in EX
import riscv_pipe_pkg::*;

module load_use_detector (
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic                 ex_valid,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    output logic                 hazard
);

    // x0 is never a real producer, so a load to x0 never stalls
    always_comb
        hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != REG_ZERO) &
                 ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, WB bypass, flush and hold
// Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
import riscv_pipe_pkg::*;

module id_ex_stage #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [XLEN-1:0]      id_pc,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [XLEN-1:0]      id_rs1_data,
    input  logic [XLEN-1:0]      id_rs2_data,
    input  logic [XLEN-1:0]      id_imm,
    input  logic [ALU_OP_W-1:0]  id_alu_op,
    input  logic                 id_alu_src,
    input  logic                 id_mem_read,
    input  logic                 id_mem_write,
    input  logic                 id_reg_write,
    input  logic                 id_mem_to_reg,
    input  logic                 id_branch,
    input  logic                 wb_reg_write,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 flush_ex,
    input  logic                 ex_hold,
    output logic                 ex_valid,
    output logic [XLEN-1:0]      ex_pc,
    output logic [XLEN-1:0]      ex_rs1_data,
    output logic [XLEN-1:0]      ex_rs2_data,
    output logic [XLEN-1:0]      ex_imm,
    output logic [REG_IDX_W-1:0] ex_rs1,
    output logic [REG_IDX_W-1:0] ex_rs2,
    output logic [REG_IDX_W-1:0] ex_rd,
    output logic [ALU_OP_W-1:0]  ex_alu_op,
    output logic                 ex_alu_src,
    output logic                 ex_mem_read,
    output logic                 ex_mem_write,
    output logic                 ex_reg_write,
    output logic                 ex_mem_to_reg,
    output logic                 ex_branch,
    output logic                 stall_if_id
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_flush_cnt,
    output logic [31:0]          perf_hold_cnt
`endif
);

    logic            hazard;
    logic            load;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    ctrl_t           id_ctrl;
    ctrl_t           ex_ctrl;

    load_use_detector u_lud (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .hazard      (hazard)
    );

    // Next-state selection, WB bypass and stall; stall is gated off while in reset
    always_comb begin
        load        = id_valid & ~flush_ex & ~hazard;
        rs1_fwd     = (wb_reg_write && wb_rd != REG_ZERO && wb_rd == id_rs1) ? wb_data : id_rs1_data;
        rs2_fwd     = (wb_reg_write && wb_rd != REG_ZERO && wb_rd == id_rs2) ? wb_data : id_rs2_data;
        id_ctrl     = '{id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch};
        stall_if_id = rst_n & (ex_hold | (hazard & ~flush_ex));
    end

    // Pipeline register: hold wins, otherwise load ID fields or a fully cleared bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_alu_op   <= '0;
            ex_ctrl     <= CTRL_BUBBLE;
        end else if (!ex_hold) begin
            ex_valid    <= load;
            ex_pc       <= load ? id_pc : '0;
            ex_rs1_data <= load ? rs1_fwd : '0;
            ex_rs2_data <= load ? rs2_fwd : '0;
            ex_imm      <= load ? id_imm : '0;
            ex_rs1      <= load ? id_rs1 : '0;
            ex_rs2      <= load ? id_rs2 : '0;
            ex_rd       <= load ? id_rd : '0;
            ex_alu_op   <= load ? id_alu_op : '0;
            ex_ctrl     <= load ? id_ctrl : CTRL_BUBBLE;
        end
    end

    assign ex_alu_src    = ex_ctrl.alu_src;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_reg_write  = ex_ctrl.reg_write;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_branch     = ex_ctrl.branch;

`ifdef ID_EX_PERF_CNT_EN
    // Count which priority rule was applied on each edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
            perf_hold_cnt  <= '0;
        end else begin
            perf_hold_cnt  <= perf_hold_cnt + {31'd0, ex_hold};
            perf_flush_cnt <= perf_flush_cnt + {31'd0, ~ex_hold & flush_ex};
            perf_stall_cnt <= perf_stall_cnt + {31'd0, ~ex_hold & ~flush_ex & hazard};
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized and directed check of id_ex_stage against a rule-level model
`timescale 1ns/1ps
module tb_id_ex_stage;

    typedef struct packed {
        logic        v;
        logic [31:0] pc, r1d, r2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  op;
        logic        alu_src, mr, mw, rw, m2r, br;
    } st_t;

    logic clk = 0, rst_n = 0;
    logic id_valid, id_uses_rs1, id_uses_rs2;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data;
    logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
    logic [3:0] id_alu_op;
    logic id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch;
    logic wb_reg_write, flush_ex, ex_hold;
    logic ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch, stall_if_id;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic [3:0] ex_alu_op;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_hold_cnt;
`endif

    int vectors = 0, errors = 0;
    st_t m, nm, got;
    logic es;
    logic [31:0] cs = 0, cf = 0, ch = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush_ex(flush_ex), .ex_hold(ex_hold), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
        .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .stall_if_id(stall_if_id)
`ifdef ID_EX_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt), .perf_hold_cnt(perf_hold_cnt)
`endif
    );

    assign got = '{ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                   ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch};

    task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic idle();
        {id_valid, id_uses_rs1, id_uses_rs2, id_alu_src, id_mem_read, id_mem_write} = '0;
        {id_reg_write, id_mem_to_reg, id_branch, wb_reg_write, flush_ex, ex_hold} = '0;
        {id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data} = '0;
        {id_rs1, id_rs2, id_rd, wb_rd, id_alu_op} = '0;
    endtask

    task automatic instr(input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic u1, input logic u2, input logic mr);
        id_valid = 1; id_pc = pc; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_mem_read = mr; id_reg_write = 1;
        id_mem_to_reg = mr; id_rs1_data = pc ^ 32'h1111; id_rs2_data = pc ^ 32'h2222;
        id_imm = pc + 32'd4; id_alu_op = pc[3:0];
    endtask

    task automatic rnd();
        id_valid = ($urandom_range(9) != 0);
        id_pc = $urandom; id_rs1 = 5'($urandom_range(3)); id_rs2 = 5'($urandom_range(3));
        id_rd = 5'($urandom_range(3)); id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
        id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom; id_alu_op = 4'($urandom);
        {id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch} = 6'($urandom);
        wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(3)); wb_data = $urandom;
        flush_ex = ($urandom_range(6) == 0);
        ex_hold = ($urandom_range(6) == 0);
    endtask

    // Rule-level model: decide what the stage should present after this edge
    task automatic cyc();
        logic haz;
        #2;
        haz = id_valid && m.v && m.mr && m.rd != 0 &&
              ((id_uses_rs1 && id_rs1 == m.rd) || (id_uses_rs2 && id_rs2 == m.rd));
        es = ex_hold || (haz && !flush_ex);
        if (ex_hold) nm = m;
        else if (flush_ex || haz || !id_valid) nm = '0;
        else begin
            nm = '{1'b1, id_pc,
                   (wb_reg_write && wb_rd != 0 && wb_rd == id_rs1) ? wb_data : id_rs1_data,
                   (wb_reg_write && wb_rd != 0 && wb_rd == id_rs2) ? wb_data : id_rs2_data,
                   id_imm, id_rs1, id_rs2, id_rd, id_alu_op,
                   id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch};
        end
        check("stall", 160'(stall_if_id), 160'(es));
        if (ex_hold) ch++;
        else if (flush_ex) cf++;
        else if (haz) cs++;
        @(posedge clk);
        #1;
        m = nm;
        check("state", 160'(got), 160'(m));
`ifdef ID_EX_PERF_CNT_EN
        check("perf", {64'd0, perf_stall_cnt, perf_flush_cnt, perf_hold_cnt}, {64'd0, cs, cf, ch});
`endif
    endtask

    initial begin
        idle();
        ex_hold = 1;
        m = '0;
        #12;
        check("reset_state", 160'(got), 160'd0);
        check("reset_stall", 160'(stall_if_id), 160'd0);
        @(negedge clk);
        rst_n = 1;
        idle();
        @(posedge clk); #1;

        instr(32'h100, 5'd3, 5'd4, 5'd5, 1, 1, 0);
        cyc();
        check("normal_pc", 160'(ex_pc), 160'h100);
        check("normal_rd", 160'(ex_rd), 160'd5);
        check("normal_v_rw", 160'({ex_valid, ex_reg_write}), 160'b11);

        instr(32'h104, 5'd1, 5'd2, 5'd7, 1, 1, 1);
        cyc();
        instr(32'h108, 5'd7, 5'd2, 5'd8, 1, 0, 0);
        cyc();
        check("lu_stall", 160'(es), 160'd1);
        check("lu_bubble", 160'({ex_valid, ex_reg_write}), 160'b00);
        cyc();
        check("lu_resume", 160'({ex_valid, ex_pc}), {127'd0, 1'b1, 32'h108});
        check("lu_no_stall", 160'(es), 160'd0);

        instr(32'h200, 5'd1, 5'd2, 5'd0, 1, 1, 1);
        cyc();
        instr(32'h204, 5'd0, 5'd2, 5'd9, 1, 1, 0);
        cyc();
        check("false_rd0", 160'(es), 160'd0);
        instr(32'h208, 5'd1, 5'd2, 5'd7, 1, 1, 1);
        cyc();
        instr(32'h20c, 5'd1, 5'd7, 5'd9, 1, 0, 0);
        cyc();
        check("false_unused_rs2", 160'(es), 160'd0);

        instr(32'h300, 5'd1, 5'd2, 5'd7, 1, 1, 1);
        cyc();
        instr(32'h304, 5'd7, 5'd2, 5'd9, 1, 1, 0);
        flush_ex = 1;
        cyc();
        check("flush_stall", 160'(es), 160'd0);
        check("flush_bubble", 160'(ex_valid), 160'd0);

        flush_ex = 0;
        instr(32'h400, 5'd1, 5'd2, 5'd3, 1, 1, 0);
        cyc();
        ex_hold = 1; flush_ex = 1;
        repeat (3) begin
            cyc();
            check("hold_pc", 160'({ex_valid, ex_pc}), {127'd0, 1'b1, 32'h400});
        end
        ex_hold = 0;
        cyc();
        check("hold_release_bubble", 160'(ex_valid), 160'd0);
        flush_ex = 0;

        instr(32'h500, 5'd3, 5'd4, 5'd5, 1, 1, 0);
        id_rs1_data = 0; wb_reg_write = 1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
        cyc();
        check("wb_bypass", 160'(ex_rs1_data), 160'hDEADBEEF);
        wb_rd = 5'd0; id_rs1 = 5'd0; id_rs1_data = 32'h55;
        cyc();
        check("wb_no_bypass_x0", 160'(ex_rs1_data), 160'h55);

        for (int i = 0; i < 400; i++) begin
            rnd();
            cyc();
        end

        #3;
        ex_hold = 1;
        rst_n = 0;
        #1;
        check("async_reset_state", 160'(got), 160'd0);
        check("async_reset_stall", 160'(stall_if_id), 160'd0);
        m = '0; cs = 0; cf = 0; ch = 0;
        @(negedge clk);
        rst_n = 1;
        idle();
        @(posedge clk); #1;
        for (int i = 0; i < 200; i++) begin
            rnd();
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
